// File: rtl/io_bus_master.sv
// io_bus_master: CPU-side initiator for the memory-mapped IO bus, sitting in the MEM stage.
// Turns pipeline load/store requests that hit the IO window into registered bus cycles,
// stalls the pipeline until each access completes, and keeps sticky error/access counters.
//
// Ports:
//   clk, rst              clock (rising edge) and synchronous active-high reset
//   req_valid/we/addr/wdata  pipeline request, held stable until rsp_valid
//   req_ready             block can accept a request this cycle
//   stall                 hold the pipeline (combinational)
//   rsp_valid, rsp_rdata  one-cycle completion pulse and load data (held until next response)
//   io_addr/io_dout/io_we registered IO bus outputs
//   io_din                IO read data, combinational function of io_addr
//   err                   sticky out-of-window flag
//   rd_cnt, wr_cnt        completed in-window read/write counters (wrapping)
module io_bus_master #(
    parameter logic [23:0] IO_BASE = 24'hFFFFFF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             req_ready,
    output logic             stall,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic [7:0]       io_addr,
    output logic [31:0]      io_dout,
    output logic             io_we,
    input  logic [31:0]      io_din,
    output logic             err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e state_q;
    logic   accept;
    logic   in_window;

    // Blocking while rsp_valid is high keeps the still-held request from being re-accepted.
    assign req_ready = (state_q == StIdle) && !rsp_valid;
    assign accept    = req_valid && req_ready;
    assign stall     = req_valid && !rsp_valid;
    assign in_window = (req_addr[31:8] == IO_BASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            io_addr   <= 8'h00;
            io_dout   <= 32'h0;
            io_we     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            err       <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (in_window) begin
                            io_addr <= req_addr[7:0];
                            if (req_we) begin
                                io_dout <= req_wdata;
                                io_we   <= 1'b1;
                                state_q <= StWr;
                            end else begin
                                state_q <= StRd;
                            end
                        end else begin
                            // Out-of-window: complete immediately, no bus activity.
                            err       <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    io_we     <= 1'b0;
                    wr_cnt    <= wr_cnt + CntOne;
                    rsp_valid <= 1'b1;
                    state_q   <= StIdle;
                end
                StRd: begin
                    rsp_rdata <= io_din;
                    rsp_valid <= 1'b1;
                    rd_cnt    <= rd_cnt + CntOne;
                    state_q   <= StIdle;
                end
                default: begin
                    io_we   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
module tb_io_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic [31:0] io_din;
    logic        err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    // Narrow-counter instance sharing the same request stream, to reach counter wrap quickly.
    logic        req_ready_n;
    logic        stall_n;
    logic        rsp_valid_n;
    logic [31:0] rsp_rdata_n;
    logic [7:0]  io_addr_n;
    logic [31:0] io_dout_n;
    logic        io_we_n;
    logic [31:0] io_din_n;
    logic        err_n;
    logic [3:0]  rd_cnt_n;
    logic [3:0]  wr_cnt_n;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_rd = 0;

    always #5 clk = ~clk;

    // Responder model: read data depends only on the address.
    assign io_din   = {24'h0, io_addr} + 32'hA500;
    assign io_din_n = {24'h0, io_addr_n} + 32'hA500;

    io_bus_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .io_addr   (io_addr),
        .io_dout   (io_dout),
        .io_we     (io_we),
        .io_din    (io_din),
        .err       (err),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    io_bus_master #(.CNT_W(4)) dut_n (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready_n),
        .stall     (stall_n),
        .rsp_valid (rsp_valid_n),
        .rsp_rdata (rsp_rdata_n),
        .io_addr   (io_addr_n),
        .io_dout   (io_dout_n),
        .io_we     (io_we_n),
        .io_din    (io_din_n),
        .err       (err_n),
        .rd_cnt    (rd_cnt_n),
        .wr_cnt    (wr_cnt_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [31:0] a,
                           input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        set_req(1'b1, 1'b1, 32'hFFFFFF0C, 32'h12345678);
        step();
        step();
        // Reset state with a request pending.
        check_eq("rst_io_addr",   32'(io_addr), 32'h0);
        check_eq("rst_io_dout",   io_dout, 32'h0);
        check_eq("rst_io_we",     32'(io_we), 32'h0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_err",       32'(err), 32'h0);
        check_eq("rst_rd_cnt",    32'(rd_cnt), 32'h0);
        check_eq("rst_wr_cnt",    32'(wr_cnt), 32'h0);
        check_eq("rst_req_ready", 32'(req_ready), 32'h1);
        check_eq("rst_stall",     32'(stall), 32'h1);

        // Store accepted in this cycle (T).
        rst = 1'b0;
        step(); // T+1
        check_eq("st_io_we_t1",   32'(io_we), 32'h1);
        check_eq("st_io_addr",    32'(io_addr), 32'h0C);
        check_eq("st_io_dout",    io_dout, 32'h12345678);
        check_eq("st_stall_t1",   32'(stall), 32'h1);
        check_eq("st_rsp_t1",     32'(rsp_valid), 32'h0);
        check_eq("st_ready_t1",   32'(req_ready), 32'h0);
        step(); // T+2
        check_eq("st_io_we_t2",   32'(io_we), 32'h0);
        check_eq("st_rsp_t2",     32'(rsp_valid), 32'h1);
        check_eq("st_stall_t2",   32'(stall), 32'h0);
        check_eq("st_wr_cnt",     32'(wr_cnt), 32'h1);
        check_eq("st_rdata_hold", rsp_rdata, 32'h0);
        check_eq("st_ready_t2",   32'(req_ready), 32'h0);

        // Back-to-back load, request stays valid across the edge ending T+2.
        set_req(1'b1, 1'b0, 32'hFFFFFF10, 32'h0);
        step(); // T+3: second accept
        check_eq("ld_ready_t3",   32'(req_ready), 32'h1);
        check_eq("ld_rsp_t3",     32'(rsp_valid), 32'h0);
        check_eq("ld_stall_t3",   32'(stall), 32'h1);
        check_eq("ld_wr_cnt_t3",  32'(wr_cnt), 32'h1);
        step(); // T+4
        check_eq("ld_io_addr",    32'(io_addr), 32'h10);
        check_eq("ld_io_we",      32'(io_we), 32'h0);
        check_eq("ld_io_dout",    io_dout, 32'h12345678);
        check_eq("ld_rsp_t4",     32'(rsp_valid), 32'h0);
        step(); // T+5
        check_eq("ld_rsp_t5",     32'(rsp_valid), 32'h1);
        check_eq("ld_rdata",      rsp_rdata, 32'hA510);
        check_eq("ld_rd_cnt",     32'(rd_cnt), 32'h1);
        check_eq("ld_stall_t5",   32'(stall), 32'h0);
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("idle_rsp",      32'(rsp_valid), 32'h0);
        check_eq("idle_ready",    32'(req_ready), 32'h1);
        check_eq("idle_rd_cnt",   32'(rd_cnt), 32'h1);
        check_eq("idle_wr_cnt",   32'(wr_cnt), 32'h1);
        exp_rd = 1;

        // Out-of-window load.
        set_req(1'b1, 1'b0, 32'h00001000, 32'h0);
        check_eq("oow_ready",     32'(req_ready), 32'h1);
        step();
        check_eq("oow_rsp",       32'(rsp_valid), 32'h1);
        check_eq("oow_rdata",     rsp_rdata, 32'h0);
        check_eq("oow_err",       32'(err), 32'h1);
        check_eq("oow_io_addr",   32'(io_addr), 32'h10);
        check_eq("oow_io_we",     32'(io_we), 32'h0);
        check_eq("oow_rd_cnt",    32'(rd_cnt), 32'h1);
        check_eq("oow_stall",     32'(stall), 32'h0);
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("oow_rsp_pulse", 32'(rsp_valid), 32'h0);
        check_eq("oow_err_stick", 32'(err), 32'h1);

        // Reads across the narrow counter's wrap point; err must remain set.
        for (int i = 0; i < 17; i++) begin
            set_req(1'b1, 1'b0, 32'hFFFFFF00 + 32'(i), 32'h0);
            step();
            step();
            exp_rd++;
            check_eq("rd_rsp",     32'(rsp_valid), 32'h1);
            check_eq("rd_rdata",   rsp_rdata, 32'hA500 + 32'(i));
            check_eq("rd_cnt16",   32'(rd_cnt), 32'(exp_rd));
            check_eq("rd_cnt4",    32'(rd_cnt_n), 32'(exp_rd % 16));
            set_req(1'b0, 1'b0, 32'h0, 32'h0);
            step();
        end
        check_eq("rd_err_stick",  32'(err), 32'h1);
        check_eq("rd_wr_cnt",     32'(wr_cnt), 32'h1);

        // Reset asserted while io_we is high.
        set_req(1'b1, 1'b1, 32'hFFFFFF20, 32'hDEADBEEF);
        step(); // T+1
        check_eq("rw_io_we_t1",   32'(io_we), 32'h1);
        check_eq("rw_io_addr_t1", 32'(io_addr), 32'h20);
        rst = 1'b1;
        step(); // T+2
        check_eq("rw_io_we_t2",   32'(io_we), 32'h0);
        check_eq("rw_wr_cnt",     32'(wr_cnt), 32'h0);
        check_eq("rw_rsp",        32'(rsp_valid), 32'h0);
        check_eq("rw_rd_cnt",     32'(rd_cnt), 32'h0);
        check_eq("rw_err",        32'(err), 32'h0);
        check_eq("rw_io_addr",    32'(io_addr), 32'h0);
        rst = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check_eq("rw_no_rsp",     32'(rsp_valid), 32'h0);
        check_eq("rw_ready",      32'(req_ready), 32'h1);
        check_eq("rw_io_we_post", 32'(io_we), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
